// File: rtl/bcd_disp_pkg.sv
// Purpose : shared constants and segment encoder for the two-digit BCD display.
// Latency : n/a (constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   SEG_OFF    - all segments dark (active-low gfedcba)
//   SEG_TABLE  - digit 0..9 to active-low gfedcba pattern
//   AN_OFF / AN_UNITS / AN_TENS - active-low digit enables, an[0]=units, an[1]=tens
//   seg_encode - table lookup; anything above 9 renders dark
package bcd_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  // Index 0 sits at the MSB end of the packed range, so the list reads 0..9.
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_OFF;
    if (digit <= 4'd9) begin
      pattern = SEG_TABLE[digit];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/cnt_sync_filter.sv
// Purpose : resynchronise the asynchronous ripple-counter value and accept it only once stable.
// Latency : a steady input change reaches value on the (3+STABLE_CYCLES)th rising edge.
// Backpressure: none; value_valid/wrap_pulse are single-cycle pulses with no ready.
//
// Ports:
//   clk, reset        - system clock, async active-high reset
//   cnt_in[3:0]       - raw ripple-counter value, asynchronous to clk
//   value[3:0]        - last accepted counter value
//   value_valid       - one-cycle pulse on the cycle value changes
//   wrap_pulse        - one-cycle pulse alongside value_valid when the new value is smaller
module cnt_sync_filter #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       wrap_pulse
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] cand;   // value currently being watched for stability
  logic [3:0] stab;   // consecutive matching samples of cand, saturates at STAB_MAX

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 4'd0;
      sync2       <= 4'd0;
      cand        <= 4'd0;
      stab        <= 4'd0;
      value       <= 4'd0;
      value_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      // Ripple bits settle at different times, so sync2 may briefly hold a
      // value the counter never really had; the run-length filter below
      // drops anything that does not persist.
      sync1 <= cnt_in;
      sync2 <= sync1;

      if (sync2 != cand) begin
        cand <= sync2;
        stab <= 4'd1;
      end else if (stab < STAB_MAX) begin
        stab <= stab + 4'd1;
      end

      value_valid <= 1'b0;
      wrap_pulse  <= 1'b0;

      // Acceptance looks at the registered cand/stab, so a value that has
      // already been seen STABLE_CYCLES times is taken even if the input
      // moves on this very cycle.
      if ((stab == STAB_MAX) && (cand != value)) begin
        value       <= cand;
        value_valid <= 1'b1;
        wrap_pulse  <= (cand < value);
      end
    end
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Purpose : filter the ripple-counter value, split it into BCD and scan a 2-digit active-low 7-seg display.
// Latency : value after 3+STABLE_CYCLES edges; seg/an update only every REFRESH_DIV edges.
// Backpressure: none; free-running display scan, status outputs are one-cycle pulses.
//
// Ports:
//   clk, reset     - system clock, async active-high reset
//   cnt_in[3:0]    - raw ripple-counter value, asynchronous to clk
//   blank_leading  - 1 = leave the tens digit dark when it is 0
//   value[3:0]     - filtered, accepted counter value
//   value_valid    - one-cycle pulse when value changes
//   wrap_pulse     - one-cycle pulse when value decreases (counter wrapped)
//   seg[6:0]       - segments {g,f,e,d,c,b,a}, active-low
//   an[1:0]        - digit enables, active-low, an[0]=units, an[1]=tens
module bcd_seg_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 1000,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       blank_leading,
  output logic [3:0] value,
  output logic       value_valid,
  output logic       wrap_pulse,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int            CW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  cnt_sync_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .cnt_in      (cnt_in),
    .value       (value),
    .value_valid (value_valid),
    .wrap_pulse  (wrap_pulse)
  );

  // BCD split of a 0..15 value: the tens digit is only ever 0 or 1.
  logic       tens;
  logic [3:0] units;

  assign tens  = (value >= 4'd10);
  assign units = tens ? (value - 4'd10) : value;

  logic [CW-1:0] refresh_cnt;
  logic          digit_sel;  // 0: next wrap shows units, 1: next wrap shows tens

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_sel   <= ~digit_sel;
      if (!digit_sel) begin
        an  <= AN_UNITS;
        seg <= seg_encode(units);
      end else if (blank_leading && !tens) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= AN_TENS;
        seg <= seg_encode({3'b000, tens});
      end
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Purpose : self-checking bench for bcd_seg_scanner against an edge-indexed reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_bcd_seg_scanner;

  localparam int R = 4;
  localparam int S = 2;

  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       blank_leading = 1'b0;
  logic [3:0] value;
  logic       value_valid;
  logic       wrap_pulse;
  logic [6:0] seg;
  logic [1:0] an;

  bcd_seg_scanner #(
    .REFRESH_DIV   (R),
    .STABLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cnt_in        (cnt_in),
    .blank_leading (blank_leading),
    .value         (value),
    .value_valid   (value_valid),
    .wrap_pulse    (wrap_pulse),
    .seg           (seg),
    .an            (an)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, indexed by rising edges since reset.
  //   cin_q[e-1]  = cnt_in seen at edge e
  //   samp(j)     = what the filter compares at edge j: cnt_in two edges earlier,
  //                 or 0 while the synchroniser still holds its reset contents.
  // A value is accepted at edge k when the S samples ending at edge k-1 all agree.
  int         m_edges;
  int         cin_q[$];
  logic [3:0] m_value;
  logic       m_vld;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  function automatic int samp(input int j);
    return (j <= 2) ? 0 : cin_q[j-3];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0;
      cin_q.delete();
      m_value = 4'd0;
      m_vld   = 1'b0;
      m_wrap  = 1'b0;
      m_seg   = 7'h7F;
      m_an    = 2'b11;
    end else begin
      int  v;
      int  tens_d;
      int  units_d;
      bit  steady;
      m_edges++;
      cin_q.push_back(int'(cnt_in));

      // Display slots use the value held before this edge.
      if (m_edges % R == 0) begin
        tens_d  = int'(m_value) / 10;
        units_d = int'(m_value) % 10;
        if ((m_edges / R) % 2 == 1) begin
          m_an  = 2'b10;
          m_seg = DIGIT_SEG[units_d];
        end else if (blank_leading && tens_d == 0) begin
          m_an  = 2'b11;
          m_seg = 7'h7F;
        end else begin
          m_an  = 2'b01;
          m_seg = DIGIT_SEG[tens_d];
        end
      end

      m_vld  = 1'b0;
      m_wrap = 1'b0;
      if (m_edges - 1 >= S) begin
        v      = samp(m_edges - 1);
        steady = 1'b1;
        for (int j = m_edges - S; j < m_edges; j++) begin
          if (samp(j) != v) steady = 1'b0;
        end
        if (steady && v != int'(m_value)) begin
          m_vld   = 1'b1;
          m_wrap  = (v < int'(m_value));
          m_value = 4'(v);
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value", 32'(value), 32'(m_value));
      chk("value_valid", 32'(value_valid), 32'(m_vld));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("an", 32'(an), 32'(m_an));
    end
  end

  initial begin
    int vld_cnt;
    int wrap_cnt;
    int both_cnt;

    #1 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_vld", 32'(value_valid), 32'd0);
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h3);
    @(negedge clk) reset = 1'b0;

    // Idle with cnt_in=0: dark until edge R, then units, then tens.
    repeat (R - 1) @(posedge clk);
    #1 chk("idle_dark_an", 32'(an), 32'h3);
    chk("idle_dark_seg", 32'(seg), 32'h7F);
    @(posedge clk);
    #1 chk("idle_units_an", 32'(an), 32'h2);
    chk("idle_units_seg", 32'(seg), 32'h40);
    repeat (R) @(posedge clk);
    #1 chk("idle_tens_an", 32'(an), 32'h1);
    chk("idle_tens_seg", 32'(seg), 32'h40);

    // 0 -> 7 held steady: accepted exactly on the 5th edge.
    @(negedge clk) cnt_in = 4'd7;
    repeat (4) @(posedge clk);
    #1 chk("lat_early_vld", 32'(value_valid), 32'd0);
    chk("lat_early_value", 32'(value), 32'd0);
    @(posedge clk);
    #1 chk("lat_value", 32'(value), 32'd7);
    chk("lat_vld", 32'(value_valid), 32'd1);
    chk("lat_wrap", 32'(wrap_pulse), 32'd0);
    @(posedge clk);
    #1 chk("lat_vld_drop", 32'(value_valid), 32'd0);
    repeat (12) @(negedge clk);

    // 13 and 4 with leading-zero blanking.
    cnt_in = 4'd13;
    blank_leading = 1'b1;
    repeat (20) @(negedge clk);
    cnt_in = 4'd4;
    repeat (20) @(negedge clk);

    // Ripple glitch 7 -> 6 -> 4 -> 8, intermediates one cycle each.
    cnt_in = 4'd7;
    repeat (10) @(negedge clk);
    cnt_in = 4'd6;
    @(negedge clk) cnt_in = 4'd4;
    @(negedge clk) cnt_in = 4'd8;
    vld_cnt  = 0;
    wrap_cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (value_valid) vld_cnt++;
      if (wrap_pulse) wrap_cnt++;
    end
    chk("glitch_vld_pulses", 32'(vld_cnt), 32'd1);
    chk("glitch_wrap_pulses", 32'(wrap_cnt), 32'd0);
    chk("glitch_value", 32'(value), 32'd8);

    // Wrap 15 -> 0.
    @(negedge clk) cnt_in = 4'd15;
    repeat (10) @(negedge clk);
    cnt_in   = 4'd0;
    vld_cnt  = 0;
    wrap_cnt = 0;
    both_cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (value_valid) vld_cnt++;
      if (wrap_pulse) wrap_cnt++;
      if (value_valid && wrap_pulse) both_cnt++;
    end
    chk("wrap_vld_pulses", 32'(vld_cnt), 32'd1);
    chk("wrap_wrap_pulses", 32'(wrap_cnt), 32'd1);
    chk("wrap_coincident", 32'(both_cnt), 32'd1);
    chk("wrap_value", 32'(value), 32'd0);

    // Randomised hold lengths, including single-cycle blips.
    @(negedge clk);
    repeat (300) begin
      cnt_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) blank_leading = ~blank_leading;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    // Reset in the middle of a scan while showing 9.
    cnt_in = 4'd9;
    repeat (12) @(negedge clk);
    chk("pre_rst_value", 32'(value), 32'd9);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_value", 32'(value), 32'd0);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_an", 32'(an), 32'h3);
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i < R; i++) begin
      @(posedge clk);
      #1 chk("post_rst_dark", 32'(an), 32'h3);
    end
    @(posedge clk);
    #1 chk("post_rst_first_an", 32'(an), 32'h2);
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
